// File: rtl/adder_block_param_if.sv
// Handshake bundle for adder_block_param: sample input, frame control,
// rescaled sum output and live sample count.
interface adder_block_param_if #(
  parameter int data_size      = 16,
  parameter int number_of_data = 10
);
  localparam int count_w = $clog2(number_of_data + 1);

  logic                 start_i;
  logic [data_size-1:0] adder_data_i;
  logic                 adder_data_valid_i;
  logic                 adder_data_ready_o;
  logic                 exp_done_i;
  logic [data_size-1:0] adder_data_o;
  logic                 adder_data_valid_o;
  logic                 adder_data_ready_i;
  logic [count_w-1:0]   count_o;

  // The adder block itself
  modport slave (
    input  start_i, adder_data_i, adder_data_valid_i, exp_done_i, adder_data_ready_i,
    output adder_data_ready_o, adder_data_o, adder_data_valid_o, count_o
  );

  // Whoever feeds samples and consumes the sum
  modport master (
    output start_i, adder_data_i, adder_data_valid_i, exp_done_i, adder_data_ready_i,
    input  adder_data_ready_o, adder_data_o, adder_data_valid_o, count_o
  );
endinterface

// File: rtl/adder_block_param.sv
// Frame accumulator for softmax exp() samples with guard bits and rescaled output.
// Define ADDER_BLOCK_ROUND_EN for round-half-up (saturating) output instead of truncation.
module adder_block_param #(
  parameter int data_size      = 16,
  parameter int number_of_data = 10,
  parameter int guard_bits     = 4
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  adder_block_param_if.slave  bus
);
  localparam int acc_w   = data_size + guard_bits;
  localparam int count_w = $clog2(number_of_data + 1);

  if ((2 ** guard_bits) < number_of_data) begin : g_guard_check
    $error("adder_block_param: 2**guard_bits must be >= number_of_data");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state;
  logic [acc_w-1:0]     acc;
  logic [count_w-1:0]   count;
  logic                 ready_r;
  logic                 valid_r;
  logic [data_size-1:0] sum_r;

  logic                 accept;
  logic [acc_w-1:0]     acc_next;
  logic [count_w-1:0]   count_next;
  logic                 last_sample;
  logic [data_size-1:0] sum_out;

  always_comb begin
    accept      = bus.adder_data_valid_i & ready_r;
    acc_next    = acc + (accept ? {{guard_bits{1'b0}}, bus.adder_data_i} : '0);
    count_next  = count + count_w'(accept);
    last_sample = accept && (count_next == count_w'(number_of_data));
  end

`ifdef ADDER_BLOCK_ROUND_EN
  logic [data_size:0] rounded;

  // Round half up on the dropped guard bits; carry out of the field saturates.
  always_comb begin
    rounded = {1'b0, acc_next[acc_w-1:guard_bits]} + (data_size + 1)'(acc_next[guard_bits-1]);
    sum_out = rounded[data_size] ? '1 : rounded[data_size-1:0];
  end
`else
  always_comb begin
    sum_out = acc_next[acc_w-1:guard_bits];
  end
`endif

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      sum_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            acc     <= '0;
            count   <= '0;
            ready_r <= 1'b1;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          // Restart wins over any sample offered in the same cycle.
          if (bus.start_i) begin
            acc   <= '0;
            count <= '0;
          end else begin
            acc   <= acc_next;
            count <= count_next;
            if (last_sample || bus.exp_done_i) begin
              sum_r   <= sum_out;
              ready_r <= 1'b0;
              valid_r <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.adder_data_ready_i) begin
            valid_r <= 1'b0;
            if (bus.start_i) begin
              acc     <= '0;
              count   <= '0;
              ready_r <= 1'b1;
              state   <= ACCUM;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          ready_r <= 1'b0;
          valid_r <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.adder_data_ready_o = ready_r;
  assign bus.adder_data_valid_o = valid_r;
  assign bus.adder_data_o       = sum_r;
  assign bus.count_o            = count;
endmodule
